// File: rtl/ntt_perm_pkg.sv
// Shared types and lane-index helper for the NTT lane-swap permutation stage.
// Lane indices are carried at a fixed width wide enough for up to 256 lanes.
package ntt_perm_pkg;

    localparam int unsigned LANE_IDX_W = 8;
    localparam int unsigned LANE_SEL_W = $clog2(LANE_IDX_W);

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    typedef struct packed {
        lane_idx_t a;
        lane_idx_t b;
`ifdef PERM_BYPASS_EN
        logic      bypass;
`endif
    } perm_cfg_t;

    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_ONE   = 2'd1,
        SK_FULL  = 2'd2
    } skid_state_e;

    // Exchange bits a and b of idx; any bit position outside the lane index leaves idx unchanged.
    function automatic lane_idx_t perm_swap_idx(lane_idx_t idx, lane_idx_t a, lane_idx_t b,
                                                lane_idx_t log_lanes);
        lane_idx_t r;
        r = idx;
        if ((a < log_lanes) && (b < log_lanes)) begin
            r[a[LANE_SEL_W-1:0]] = idx[b[LANE_SEL_W-1:0]];
            r[b[LANE_SEL_W-1:0]] = idx[a[LANE_SEL_W-1:0]];
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_lane_swap_permute_if.sv
// Stream interface for the lane-swap permutation stage: input beat port and output beat port.
interface ntt_lane_swap_permute_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 32
);
    localparam int unsigned BUS_W = DATA_W * LANES;

    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [BUS_W-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/ntt_perm_skid.sv
// Generic 2-entry valid/ready buffer: an output register backed by one skid register.
// in_ready depends only on buffer occupancy and rst, never on out_ready.
module ntt_perm_skid
    import ntt_perm_pkg::*;
#(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state;
    skid_state_e  state_nxt;
    logic [W-1:0] out_q;
    logic [W-1:0] skid_q;
    logic         load_out;
    logic         out_from_skid;
    logic         load_skid;
    logic         accept;
    logic         consume;

    assign in_ready  = (state != SK_FULL) & ~rst;
    assign out_valid = (state != SK_EMPTY);
    assign out_data  = out_q;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= SK_EMPTY;
        else     state <= state_nxt;
    end

    // Occupancy transitions; the skid entry always drains into the output register first.
    always_comb begin
        state_nxt     = state;
        load_out      = 1'b0;
        out_from_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            SK_EMPTY: begin
                if (accept) begin
                    load_out  = 1'b1;
                    state_nxt = SK_ONE;
                end
            end
            SK_ONE: begin
                if (consume) begin
                    if (accept) load_out  = 1'b1;
                    else        state_nxt = SK_EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = SK_FULL;
                end
            end
            SK_FULL: begin
                if (consume) begin
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                    state_nxt     = SK_ONE;
                end
            end
            default: state_nxt = SK_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out)  out_q  <= out_from_skid ? skid_q : in_data;
            if (load_skid) skid_q <= in_data;
        end
    end

endmodule

// File: rtl/ntt_lane_swap_permute.sv
// Runtime-configurable lane-swap permutation stage with frame tracking and per-frame cfg latch.
// Optional PERM_BYPASS_EN adds cfg_bypass, latched per frame, forcing identity order.
module ntt_lane_swap_permute
    import ntt_perm_pkg::*;
#(
    parameter  int unsigned DATA_W      = 32,
    parameter  int unsigned LANES       = 32,
    parameter  int unsigned FRAME_BEATS = 32,
    localparam int unsigned LOG_LANES   = $clog2(LANES)
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef PERM_BYPASS_EN
    input  logic                 cfg_bypass,
`endif
    input  logic [LOG_LANES-1:0] cfg_bit_a,
    input  logic [LOG_LANES-1:0] cfg_bit_b,
    ntt_lane_swap_permute_if.slave bus
);

    localparam int unsigned BUS_W = DATA_W * LANES;
    localparam int unsigned CNT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_BEATS - 1);

    logic               in_ready;
    logic               accept;
    logic [CNT_W-1:0]   beat_cnt;
    perm_cfg_t          cfg_live;
    perm_cfg_t          cfg_q;
    perm_cfg_t          cfg_beat;
    logic               beat_last;
    logic [DATA_W-1:0]  in_lane [LANES];
    logic [BUS_W-1:0]   perm_data;
    logic [BUS_W:0]     out_payload;

    assign bus.in_ready = in_ready;
    assign accept       = bus.in_valid & in_ready;

    always_comb begin
        cfg_live   = '0;
        cfg_live.a = LANE_IDX_W'(cfg_bit_a);
        cfg_live.b = LANE_IDX_W'(cfg_bit_b);
`ifdef PERM_BYPASS_EN
        cfg_live.bypass = cfg_bypass;
`endif
    end

    // Beat 0 of a frame uses the live cfg and latches it for the remaining beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            cfg_q    <= '0;
        end else if (accept) begin
            if (beat_cnt == '0) cfg_q <= cfg_live;
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
        end
    end

    assign cfg_beat  = (beat_cnt == '0) ? cfg_live : cfg_q;
    assign beat_last = (beat_cnt == LAST_BEAT);

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        lane_idx_t src;

        assign in_lane[j] = bus.in_data[j*DATA_W +: DATA_W];
`ifdef PERM_BYPASS_EN
        assign src = cfg_beat.bypass ? LANE_IDX_W'(j)
                   : perm_swap_idx(LANE_IDX_W'(j), cfg_beat.a, cfg_beat.b, LANE_IDX_W'(LOG_LANES));
`else
        assign src = perm_swap_idx(LANE_IDX_W'(j), cfg_beat.a, cfg_beat.b, LANE_IDX_W'(LOG_LANES));
`endif
        // src is always below LANES, so only its low LOG_LANES bits select the lane.
        assign perm_data[j*DATA_W +: DATA_W] = in_lane[src[LOG_LANES-1:0]];

        if (LOG_LANES < LANE_IDX_W) begin : g_hi
            logic unused_src_hi;
            assign unused_src_hi = ^src[LANE_IDX_W-1:LOG_LANES];
        end
    end

    ntt_perm_skid #(
        .W (BUS_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (in_ready),
        .in_data   ({beat_last, perm_data}),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_payload)
    );

    assign bus.out_last = out_payload[BUS_W];
    assign bus.out_data = out_payload[BUS_W-1:0];

endmodule

// File: tb/tb_ntt_lane_swap_permute.sv
// Directed + randomized bench for ntt_lane_swap_permute against a queue-based reference model.
module tb_ntt_lane_swap_permute;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned LANES       = 32;
    localparam int unsigned FRAME_BEATS = 32;
    localparam int unsigned LOG_LANES   = $clog2(LANES);
    localparam int unsigned BUS_W       = DATA_W * LANES;

    typedef struct {
        logic [BUS_W-1:0] data;
        logic             last;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic [LOG_LANES-1:0] cfg_a;
    logic [LOG_LANES-1:0] cfg_b;
    logic                 cfg_byp;

    ntt_lane_swap_permute_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

    ntt_lane_swap_permute #(
        .DATA_W      (DATA_W),
        .LANES       (LANES),
        .FRAME_BEATS (FRAME_BEATS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef PERM_BYPASS_EN
        .cfg_bypass (cfg_byp),
`endif
        .cfg_bit_a  (cfg_a),
        .cfg_bit_b  (cfg_b),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_pass;
    int   n_fail;
    int   n_total;
    exp_t exp_q [$];
    int   m_cnt;
    int   m_a;
    int   m_b;
    bit   m_byp;
    bit   acc_seen;
    int   last_cnt;
    bit   hold_pend;
    logic [BUS_W-1:0] hold_data;
    logic             hold_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Source lane for output lane j: bits a and b of j exchanged, identity if either is out of range.
    function automatic int src_lane(int j, int a, int b);
        int ba;
        int bb;
        if (a >= int'(LOG_LANES) || b >= int'(LOG_LANES)) return j;
        ba = (j >> a) & 1;
        bb = (j >> b) & 1;
        return j - (ba << a) - (bb << b) + (bb << a) + (ba << b);
    endfunction

    task automatic model_push();
        exp_t e;
        int   s;
        if (m_cnt == 0) begin
            m_a   = int'(cfg_a);
            m_b   = int'(cfg_b);
            m_byp = cfg_byp;
        end
        for (int j = 0; j < int'(LANES); j++) begin
            s = m_byp ? j : src_lane(j, m_a, m_b);
            e.data[j*DATA_W +: DATA_W] = bus.in_data[s*DATA_W +: DATA_W];
        end
        e.last = (m_cnt == int'(FRAME_BEATS) - 1);
        m_cnt  = (m_cnt + 1) % int'(FRAME_BEATS);
        exp_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        int   bad;
        if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(bus.out_valid), 32'd0);
            return;
        end
        e   = exp_q.pop_front();
        bad = 0;
        for (int j = 0; j < int'(LANES); j++)
            if (bus.out_data[j*DATA_W +: DATA_W] !== e.data[j*DATA_W +: DATA_W]) begin
                bad = j;
                break;
            end
        check($sformatf("out_data_lane%0d", bad), bus.out_data[bad*DATA_W +: DATA_W],
              e.data[bad*DATA_W +: DATA_W]);
        check("out_last", 32'(bus.out_last), 32'(e.last));
        if (bus.out_last === 1'b1) last_cnt++;
    endtask

    // One clock: observe handshakes at the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        acc_seen = 1'b0;
        if (rst) begin
            exp_q.delete();
            m_cnt     = 0;
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_data", 32'(bus.out_data === hold_data), 32'd1);
                check("hold_last", 32'(bus.out_last === hold_last), 32'd1);
            end
            if (bus.out_valid && bus.out_ready) compare_out();
            if (bus.in_valid && bus.in_ready) begin
                acc_seen = 1'b1;
                model_push();
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
            hold_last = bus.out_last;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat();
        for (int k = 0; k < int'(LANES); k++) bus.in_data[k*DATA_W +: DATA_W] = $urandom;
    endtask

    task automatic index_beat();
        for (int k = 0; k < int'(LANES); k++) bus.in_data[k*DATA_W +: DATA_W] = DATA_W'(k);
    endtask

    task automatic run_beats(input int n, input bit stall);
        int sent;
        int budget;
        sent   = 0;
        budget = 0;
        rand_beat();
        while (sent < n && budget < n * 20) begin
            bus.in_valid  = 1'b1;
            bus.out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            budget++;
            if (acc_seen) begin
                sent++;
                rand_beat();
            end
        end
        bus.in_valid = 1'b0;
        check("beats_sent", 32'(sent), 32'(n));
    endtask

    task automatic drain();
        int budget;
        budget        = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && budget < 100) begin
            tick();
            budget++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(bus.out_valid), 32'd0);
    endtask

    // Send one beat into an idle stage and confirm it appears exactly one cycle later.
    task automatic lead_beat(output logic [BUS_W-1:0] sent);
        sent          = bus.in_data;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        check("lead_pre_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("lead_accepted", 32'(acc_seen), 32'd1);
        check("lead_latency", 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BUS_W-1:0] sent;
        int               tbl [16];
        int               nacc;

        tbl = '{0, 4, 2, 6, 1, 5, 3, 7, 8, 12, 10, 14, 9, 13, 11, 15};
        n_pass = 0; n_fail = 0; n_total = 0;
        m_cnt = 0; m_a = 0; m_b = 0; m_byp = 1'b0;
        last_cnt = 0; hold_pend = 1'b0; hold_data = '0; hold_last = 1'b0;
        rst = 1'b1; cfg_a = '0; cfg_b = '0; cfg_byp = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data_or", 32'(|bus.out_data), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // a=0, b=2 on lane k=k
        cfg_a = 5'd0; cfg_b = 5'd2;
        index_beat();
        lead_beat(sent);
        for (int j = 0; j < 16; j++)
            check($sformatf("swap02_lane%0d", j), bus.out_data[j*DATA_W +: DATA_W], 32'(tbl[j]));
        run_beats(FRAME_BEATS - 1, 1'b0);
        drain();

        // a==b and out-of-range cfg both give identity
        cfg_a = 5'd3; cfg_b = 5'd3;
        rand_beat();
        lead_beat(sent);
        check("ident_eq", 32'(bus.out_data === sent), 32'd1);
        run_beats(FRAME_BEATS - 1, 1'b0);
        drain();
        cfg_a = 5'd7; cfg_b = 5'd1;
        rand_beat();
        lead_beat(sent);
        check("ident_oor", 32'(bus.out_data === sent), 32'd1);
        run_beats(FRAME_BEATS - 1, 1'b0);
        drain();

        // Output stalled for 4 cycles under continuous input
        cfg_a = 5'd1; cfg_b = 5'd4;
        rand_beat();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (acc_seen) begin
                nacc++;
                rand_beat();
            end
        end
        check("stall_accepts", 32'(nacc), 32'd2);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        run_beats(FRAME_BEATS - 2, 1'b0);
        drain();

        // Two frames, cfg changed mid-frame 0
        last_cnt = 0;
        cfg_a = 5'd0; cfg_b = 5'd4;
        run_beats(5, 1'b1);
        cfg_a = 5'd1; cfg_b = 5'd3;
        run_beats(2 * FRAME_BEATS - 5, 1'b1);
        drain();
        check("last_count_2frames", 32'(last_cnt), 32'd2);

        // Reset mid-frame with the output stalled
        cfg_a = 5'd2; cfg_b = 5'd3;
        run_beats(10, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        rand_beat();
        tick();
        tick();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        last_cnt = 0;
        cfg_a = 5'd4; cfg_b = 5'd0;
        run_beats(FRAME_BEATS - 1, 1'b1);
        drain();
        check("midrst_no_early_last", 32'(last_cnt), 32'd0);
        run_beats(1, 1'b0);
        drain();
        check("midrst_last_on_32nd", 32'(last_cnt), 32'd1);

        // Bypass (only present when the feature is built in)
        cfg_a = 5'd0; cfg_b = 5'd2;
`ifdef PERM_BYPASS_EN
        cfg_byp = 1'b1;
`endif
        index_beat();
        lead_beat(sent);
`ifdef PERM_BYPASS_EN
        check("bypass_lane1", bus.out_data[1*DATA_W +: DATA_W], 32'd1);
`else
        check("perm_lane1", bus.out_data[1*DATA_W +: DATA_W], 32'd4);
`endif
        run_beats(FRAME_BEATS - 1, 1'b0);
        drain();
        cfg_byp = 1'b0;

        // Random frames with random cfg and back-pressure
        for (int f = 0; f < 3; f++) begin
            cfg_a = LOG_LANES'($urandom_range(0, LOG_LANES - 1));
            cfg_b = LOG_LANES'($urandom_range(0, LOG_LANES - 1));
            run_beats(FRAME_BEATS, 1'b1);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
